// File: rtl/gb_fb_scan_ctrl_if.sv
// rtl/gb_fb_scan_ctrl_if.sv - raster position in, frame buffer read address and pixel flags out
interface gb_fb_scan_ctrl_if;
  logic [15:0] LX;
  logic [15:0] LY;
  logic        grid_en;
  logic        swap_req;
  logic [15:0] rd_addr;
  logic        in_window;
  logic        grid;
  logic        display_bank;
  logic        swap_ack;
  logic [7:0]  drop_cnt;

  modport master (
    output LX, LY, grid_en, swap_req,
    input  rd_addr, in_window, grid, display_bank, swap_ack, drop_cnt
  );

  modport slave (
    input  LX, LY, grid_en, swap_req,
    output rd_addr, in_window, grid, display_bank, swap_ack, drop_cnt
  );
endinterface

// File: rtl/gb_fb_scan_ctrl.sv
// rtl/gb_fb_scan_ctrl.sv - GameBoy frame buffer read scan with integer scaling and tear-free bank swap
module gb_fb_scan_ctrl #(
  parameter int H_ORIGIN = 160,
  parameter int V_ORIGIN = 80,
  parameter int GB_W     = 160,
  parameter int GB_H     = 144,
  parameter int X_SCALE  = 6,
  parameter int Y_SCALE  = 6
) (
  input  logic              clk_vga,
  input  logic              reset,
  gb_fb_scan_ctrl_if.slave  bus
);

  localparam logic [15:0] H_LO     = 16'(H_ORIGIN);
  localparam logic [15:0] H_HI     = 16'(H_ORIGIN + GB_W * X_SCALE);
  localparam logic [15:0] V_LO     = 16'(V_ORIGIN);
  localparam logic [15:0] V_HI     = 16'(V_ORIGIN + GB_H * Y_SCALE);
  localparam logic [7:0]  X_LAST   = 8'(X_SCALE - 1);
  localparam logic [7:0]  Y_LAST   = 8'(Y_SCALE - 1);
  localparam logic [14:0] ROW_STEP = 15'(GB_W);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  state_t      r_state;
  logic [7:0]  r_col_cnt;
  logic [14:0] r_gb_x;
  logic [7:0]  r_row_cnt;
  logic [14:0] r_row_base;
  logic [15:0] r_rd_addr;
  logic        r_win1;
  logic        r_grid1;
  logic        r_win2;
  logic        r_grid2;
  logic        r_bank;
  logic        r_swap_ack;
  logic [7:0]  r_drop_cnt;

  logic        w_hwin;
  logic        w_vwin;
  logic        w_win;
  logic [7:0]  w_col_nxt;
  logic [14:0] w_gb_x_nxt;
  logic [7:0]  w_row_nxt;
  logic [14:0] w_row_base_nxt;
  logic [14:0] w_index;
  logic        w_swap_pt;
  logic        w_do_swap;
  logic        w_bank_nxt;

  assign w_hwin = (bus.LX >= H_LO) && (bus.LX < H_HI);
  assign w_vwin = (bus.LY >= V_LO) && (bus.LY < V_HI);
  assign w_win  = w_hwin && w_vwin;

  always_comb begin
    w_col_nxt  = 8'd0;
    w_gb_x_nxt = 15'd0;
    if (bus.LX == H_LO) begin
      w_col_nxt  = 8'd0;
      w_gb_x_nxt = 15'd0;
    end else if (w_hwin) begin
      if (r_col_cnt == X_LAST) begin
        w_col_nxt  = 8'd0;
        w_gb_x_nxt = r_gb_x + 15'd1;
      end else begin
        w_col_nxt  = r_col_cnt + 8'd1;
        w_gb_x_nxt = r_gb_x;
      end
    end
  end

  // Row state advances once per line, on the LX==0 cycle; row_base steps by GB_W instead of multiplying.
  always_comb begin
    w_row_nxt      = r_row_cnt;
    w_row_base_nxt = r_row_base;
    if (bus.LX == 16'd0) begin
      if (bus.LY == V_LO || !w_vwin) begin
        w_row_nxt      = 8'd0;
        w_row_base_nxt = 15'd0;
      end else if (r_row_cnt == Y_LAST) begin
        w_row_nxt      = 8'd0;
        w_row_base_nxt = r_row_base + ROW_STEP;
      end else begin
        w_row_nxt      = r_row_cnt + 8'd1;
      end
    end
  end

  assign w_index    = w_row_base_nxt + w_gb_x_nxt;
  assign w_swap_pt  = (bus.LX == 16'd0) && (bus.LY == V_HI);
  assign w_do_swap  = w_swap_pt && ((r_state == ST_PENDING) || bus.swap_req);
  // The address registered on the swap edge already carries the new bank.
  assign w_bank_nxt = r_bank ^ w_do_swap;

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r_col_cnt  <= 8'd0;
      r_gb_x     <= 15'd0;
      r_row_cnt  <= 8'd0;
      r_row_base <= 15'd0;
      r_rd_addr  <= 16'd0;
      r_win1     <= 1'b0;
      r_grid1    <= 1'b0;
      r_win2     <= 1'b0;
      r_grid2    <= 1'b0;
    end else begin
      r_col_cnt  <= w_col_nxt;
      r_gb_x     <= w_gb_x_nxt;
      r_row_cnt  <= w_row_nxt;
      r_row_base <= w_row_base_nxt;
      r_rd_addr  <= w_win ? {w_bank_nxt, w_index} : {w_bank_nxt, 15'd0};
      r_win1     <= w_win;
      r_grid1    <= w_win && bus.grid_en && (w_col_nxt == 8'd0 || w_row_nxt == 8'd0);
      r_win2     <= r_win1;
      r_grid2    <= r_grid1;
    end
  end

  // A request arriving while one is already pending is coalesced and counted as dropped.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bank     <= 1'b0;
      r_swap_ack <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_swap_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_do_swap) begin
            r_bank     <= w_bank_nxt;
            r_swap_ack <= 1'b1;
          end else if (bus.swap_req && !w_swap_pt) begin
            r_state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (w_swap_pt) begin
            r_bank     <= w_bank_nxt;
            r_swap_ack <= 1'b1;
            if (!bus.swap_req) r_state <= ST_IDLE;
          end
          if (bus.swap_req && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_addr      = r_rd_addr;
  assign bus.in_window    = r_win2;
  assign bus.grid         = r_grid2;
  assign bus.display_bank = r_bank;
  assign bus.swap_ack     = r_swap_ack;
  assign bus.drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_gb_fb_scan_ctrl.sv
// tb/tb_gb_fb_scan_ctrl.sv - scoreboard bench for the frame buffer scan controller
module tb_gb_fb_scan_ctrl;

  localparam int HO = 160;
  localparam int VO = 80;
  localparam int HE = 1120;
  localparam int VE = 944;

  logic clk_vga = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic       exp_bank = 1'b0;
  logic [7:0] exp_drop = 8'd0;
  logic [15:0] q_addr[$];
  logic [1:0]  q_flag[$];

  gb_fb_scan_ctrl_if bus ();

  gb_fb_scan_ctrl dut (
    .clk_vga (clk_vga),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h (LX=%0d LY=%0d)", tag, got, exp, bus.LX, bus.LY);
    end
  endtask

  // Drive one raster position; expected address comes out one edge later, flags two edges later.
  task automatic step(input int lx, input int ly, input logic req, input logic ack_exp);
    logic        win;
    logic        g;
    logic [15:0] a;
    logic [1:0]  f;
    int          gx, gy, cx, ry;
    bus.LX       = 16'(lx);
    bus.LY       = 16'(ly);
    bus.swap_req = req;
    win = (lx >= HO) && (lx < HE) && (ly >= VO) && (ly < VE);
    if (win) begin
      gx = (lx - HO) / 6;
      cx = (lx - HO) % 6;
      gy = (ly - VO) / 6;
      ry = (ly - VO) % 6;
      a  = {exp_bank, 15'(gy * 160 + gx)};
      g  = bus.grid_en && (cx == 0 || ry == 0);
    end else begin
      a = {exp_bank, 15'd0};
      g = 1'b0;
    end
    q_addr.push_back(a);
    q_flag.push_back({win, g});
    @(posedge clk_vga);
    #1;
    bus.swap_req = 1'b0;
    a = q_addr.pop_front();
    check_eq("rd_addr", 32'(bus.rd_addr), 32'(a));
    if (q_flag.size() >= 2) begin
      f = q_flag.pop_front();
      check_eq("in_window", 32'(bus.in_window), 32'(f[1]));
      check_eq("grid", 32'(bus.grid), 32'(f[0]));
    end
    check_eq("display_bank", 32'(bus.display_bank), 32'(exp_bank));
    check_eq("swap_ack", 32'(bus.swap_ack), 32'(ack_exp));
    check_eq("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_vga);
    #1;
    reset = 1'b0;
    exp_bank = 1'b0;
    exp_drop = 8'd0;
    q_addr.delete();
    q_flag.delete();
    check_eq("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
    check_eq("rst_in_window", 32'(bus.in_window), 32'd0);
    check_eq("rst_grid", 32'(bus.grid), 32'd0);
    check_eq("rst_bank", 32'(bus.display_bank), 32'd0);
    check_eq("rst_ack", 32'(bus.swap_ack), 32'd0);
    check_eq("rst_drop", 32'(bus.drop_cnt), 32'd0);
  endtask

  function automatic bit full_line(input int ly);
    return (ly == 80 || ly == 81 || ly == 86 || ly == 938 || ly == 943);
  endfunction

  task automatic scan(input int lo, input int hi);
    for (int ly = lo; ly <= hi; ly++) begin
      bus.grid_en = !(ly >= 100 && ly <= 130);
      step(0, ly, 1'b0, 1'b0);
      if (ly == 500) step(5, ly, 1'b1, 1'b0);
      if (full_line(ly)) begin
        for (int lx = HO - 2; lx <= HE + 1; lx++) step(lx, ly, 1'b0, 1'b0);
      end else begin
        for (int lx = HO - 2; lx <= HO + 8; lx++) step(lx, ly, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    bus.LX = 16'd0;
    bus.LY = 16'd0;
    bus.grid_en = 1'b1;
    bus.swap_req = 1'b0;
    do_reset();

    // Full frame with a swap request on line 500; the swap lands only at line 944.
    scan(VO, VE - 1);
    exp_bank = 1'b1;
    step(0, VE, 1'b0, 1'b1);
    step(200, VE, 1'b0, 1'b0);
    step(201, VE, 1'b0, 1'b0);
    step(202, VE, 1'b0, 1'b0);

    // Three requests in one frame coalesce into one swap.
    step(5, 200, 1'b1, 1'b0);
    step(5, 200, 1'b0, 1'b0);
    exp_drop = 8'd1;
    step(5, 200, 1'b1, 1'b0);
    step(5, 200, 1'b0, 1'b0);
    exp_drop = 8'd2;
    step(5, 200, 1'b1, 1'b0);
    exp_bank = ~exp_bank;
    step(0, VE, 1'b0, 1'b1);
    step(5, VE + 1, 1'b0, 1'b0);

    // Drop counter saturation.
    step(5, 200, 1'b1, 1'b0);
    for (int i = 0; i < 260; i++) begin
      if (exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
      step(5, 200, 1'b1, 1'b0);
      step(5, 200, 1'b0, 1'b0);
    end
    exp_bank = ~exp_bank;
    step(0, VE, 1'b0, 1'b1);
    step(5, VE + 1, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    step(50, 500, 1'b0, 1'b0);
    do_reset();

    // Request on the swap-point cycle while idle, then an idle swap point.
    exp_bank = 1'b1;
    step(0, VE, 1'b1, 1'b1);
    step(5, VE + 1, 1'b0, 1'b0);
    step(0, VE, 1'b0, 1'b0);
    step(5, VE + 1, 1'b0, 1'b0);

    // Request on the swap-point cycle while pending is served next frame.
    step(5, 200, 1'b1, 1'b0);
    exp_bank = 1'b0;
    exp_drop = 8'd1;
    step(0, VE, 1'b1, 1'b1);
    step(5, VE + 1, 1'b0, 1'b0);
    exp_bank = 1'b1;
    step(0, VE, 1'b0, 1'b1);
    step(5, VE + 1, 1'b0, 1'b0);
    step(0, VE, 1'b0, 1'b0);

    // Scanning resumes from the next window entry after reset.
    scan(VO, VO + 8);
    step(5, VO + 9, 1'b0, 1'b0);
    step(6, VO + 9, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
